// File: rtl/proj_pkg.sv
// Shared types for the extender sequencing controller: FSM states and the
// beat word carried through the output FIFO.
package proj_pkg;

    localparam int EXT_INDICE_LEN = 5;
    localparam int EXT_FRAG_PART  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } ext_ctrl_state_t;

    typedef struct packed {
        logic [EXT_INDICE_LEN-1:0] index;
        logic [EXT_FRAG_PART-1:0]  gfm;
        logic                      clip;
        logic                      last_part;
        logic                      last;
    } ext_beat_t;

endpackage

// File: rtl/proj_extender.sv
// Free-running kmer extender: walks every fragment slice for each kmer index
// and emits (kmer index - OFFSET, slice) once per cycle; rst_n restarts the walk.
module proj_extender #(
    parameter int KMER_LEN      = 4,
    parameter int FRAG_LEN      = 8,
    parameter int INDICES_COUNT = 3,
    parameter int INDICE_LEN    = 5,
    parameter int FRAG_PART     = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [FRAG_LEN-1:0]                 fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] kmer_indices,
    output logic [INDICE_LEN-1:0]               index,
    output logic [FRAG_PART-1:0]                gfm
);
    localparam int PARTS  = FRAG_LEN / FRAG_PART;
    localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;
    localparam int PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int KMER_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam logic [INDICE_LEN-1:0] OFFSET_V = INDICE_LEN'(OFFSET);

    logic [PART_W-1:0]     part_cnt;
    logic [KMER_W-1:0]     kmer_cnt;
    logic [INDICE_LEN-1:0] sel_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_cnt <= '0;
            kmer_cnt <= '0;
        end else if (part_cnt == PART_W'(PARTS - 1)) begin
            part_cnt <= '0;
            kmer_cnt <= (kmer_cnt == KMER_W'(INDICES_COUNT - 1)) ? '0 : kmer_cnt + 1'b1;
        end else begin
            part_cnt <= part_cnt + 1'b1;
        end
    end

    // Subtraction wraps modulo 2^INDICE_LEN for indices below OFFSET.
    always_comb begin
        sel_idx = kmer_indices[int'(kmer_cnt)*INDICE_LEN +: INDICE_LEN];
        index   = sel_idx - OFFSET_V;
        gfm     = fragment[int'(part_cnt)*FRAG_PART +: FRAG_PART];
    end

endmodule

// File: rtl/proj_sync_fifo.sv
// Single-clock FIFO with a free-entry count; pops on empty are ignored and a
// push while full is legal only together with a pop.
module proj_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);
    localparam int AW = $clog2(DEPTH);

    if ((1 << AW) != DEPTH) begin : g_depth_pow2
        $error("proj_sync_fifo: DEPTH must be a power of 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop_eff;
    logic             push_eff;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign free     = (AW+1)'(DEPTH) - count;
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_eff, pop_eff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!full || pop));

endmodule

// File: rtl/proj_extender_ctrl.sv
// Accepts a job, clears the extender for one cycle, then streams its TOTAL
// beats into an output FIFO sized so that a started job can never stall.
module proj_extender_ctrl
    import proj_pkg::*;
#(
    parameter int KMER_LEN      = 4,
    parameter int FRAG_LEN      = 8,
    parameter int INDICES_COUNT = 3,
    parameter int INDICE_LEN    = 5,
    parameter int FRAG_PART     = 2,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FRAG_LEN-1:0]                 in_fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INDICE_LEN-1:0]               out_index,
    output logic [FRAG_PART-1:0]                out_gfm,
    output logic                                out_clip,
    output logic                                out_last_part,
    output logic                                out_last,
    output logic                                busy,
    output ext_ctrl_state_t                     dbg_state
);
    localparam int PARTS  = FRAG_LEN / FRAG_PART;
    localparam int TOTAL  = INDICES_COUNT * PARTS;
    localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;
    localparam int PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int KMER_W = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int BEAT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INDICE_LEN-1:0] OFFSET_V = INDICE_LEN'(OFFSET);

    if (FIFO_DEPTH < TOTAL) begin : g_depth_chk
        $error("proj_extender_ctrl: FIFO_DEPTH must hold a whole job");
    end
    if (INDICE_LEN != EXT_INDICE_LEN || FRAG_PART != EXT_FRAG_PART) begin : g_beat_chk
        $error("proj_extender_ctrl: ext_beat_t field widths do not match parameters");
    end

    ext_ctrl_state_t state, state_next;

    logic [FRAG_LEN-1:0]                 job_frag;
    logic [INDICES_COUNT*INDICE_LEN-1:0] job_idx;
    logic [BEAT_W-1:0]                   beat_cnt;
    logic [KMER_W-1:0]                   kmer_cnt;
    logic [PART_W-1:0]                   part_cnt;
    logic [INDICE_LEN-1:0]               job_kmer_idx;
    logic                                ext_rst_n;
    logic [INDICE_LEN-1:0]               ext_index;
    logic [FRAG_PART-1:0]                ext_gfm;
    logic                                accept;
    logic                                fifo_push;
    logic                                fifo_empty;
    logic [FREE_W-1:0]                   fifo_free;
    ext_beat_t                           push_beat;
    ext_beat_t                           pop_beat;
    ext_beat_t                           out_beat;

    // Handshakes: a job transfers on the cycle in_valid && in_ready are both
    // high; a beat transfers when out_valid && out_ready. in_ready only rises
    // in IDLE when the FIFO has room for every beat of a full job.
    assign in_ready  = (state == IDLE) && (fifo_free >= FREE_W'(TOTAL));
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign ext_rst_n = rst_n & (state != CLR);
    assign fifo_push = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CLR;
            CLR:     state_next = RUN;
            RUN:     if (beat_cnt == BEAT_W'(TOTAL - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_frag <= '0;
            job_idx  <= '0;
            beat_cnt <= '0;
            kmer_cnt <= '0;
            part_cnt <= '0;
        end else begin
            if (accept) begin
                job_frag <= in_fragment;
                job_idx  <= in_kmer_indices;
            end
            if (state == CLR) begin
                beat_cnt <= '0;
                kmer_cnt <= '0;
                part_cnt <= '0;
            end else if (state == RUN) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (part_cnt == PART_W'(PARTS - 1)) begin
                    part_cnt <= '0;
                    kmer_cnt <= kmer_cnt + 1'b1;
                end else begin
                    part_cnt <= part_cnt + 1'b1;
                end
            end
        end
    end

    proj_extender #(
        .KMER_LEN      (KMER_LEN),
        .FRAG_LEN      (FRAG_LEN),
        .INDICES_COUNT (INDICES_COUNT),
        .INDICE_LEN    (INDICE_LEN),
        .FRAG_PART     (FRAG_PART)
    ) u_extender (
        .clk          (clk),
        .rst_n        (ext_rst_n),
        .fragment     (job_frag),
        .kmer_indices (job_idx),
        .index        (ext_index),
        .gfm          (ext_gfm)
    );

    // Clip is derived from the controller's own kmer counter, which tracks the
    // extender's selection because both restart on the CLR cycle.
    always_comb begin
        job_kmer_idx        = job_idx[int'(kmer_cnt)*INDICE_LEN +: INDICE_LEN];
        push_beat.index     = ext_index;
        push_beat.gfm       = ext_gfm;
        push_beat.clip      = (job_kmer_idx < OFFSET_V);
        push_beat.last_part = (part_cnt == PART_W'(PARTS - 1));
        push_beat.last      = (beat_cnt == BEAT_W'(TOTAL - 1));
    end

    proj_sync_fifo #(
        .WIDTH ($bits(ext_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_beat),
        .pop       (out_ready),
        .pop_data  (pop_beat),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    assign out_valid     = !fifo_empty;
    assign out_beat      = fifo_empty ? '0 : pop_beat;
    assign out_index     = out_beat.index;
    assign out_gfm       = out_beat.gfm;
    assign out_clip      = out_beat.clip;
    assign out_last_part = out_beat.last_part;
    assign out_last      = out_beat.last;

endmodule

// File: tb/tb_proj_extender_ctrl.sv
// Bench for proj_extender_ctrl: directed jobs plus random traffic, checked by
// a scoreboard fed from a job-level reference model.
module tb_proj_extender_ctrl;
    import proj_pkg::*;

    localparam int W      = 10;
    localparam int TOTAL  = 12;
    localparam int OFFSET = 2;
    localparam int DEPTH  = 16;
    localparam int JOB_CYCLES = 13;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_fragment = '0;
    logic [14:0]     in_kmer_indices = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4:0]      out_index;
    logic [1:0]      out_gfm;
    logic            out_clip;
    logic            out_last_part;
    logic            out_last;
    logic            busy;
    ext_ctrl_state_t dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int timer = 0;
    int last_acc = 0;
    bit interval_armed = 0;
    bit chk_interval = 0;
    logic [W-1:0] exp_q[$];

    proj_extender_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_fragment     (in_fragment),
        .in_kmer_indices (in_kmer_indices),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_index       (out_index),
        .out_gfm         (out_gfm),
        .out_clip        (out_clip),
        .out_last_part   (out_last_part),
        .out_last        (out_last),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one job expands into TOTAL beats, kmer-major, slice LSB first.
    task automatic model_job(input logic [7:0] frag, input logic [14:0] idxs);
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) begin
                int src, ix, g;
                logic [4:0] ixv;
                logic [1:0] gv;
                src = int'((idxs >> (5 * k)) & 15'd31);
                ix  = (src + 32 - OFFSET) % 32;
                g   = int'((frag >> (2 * p)) & 8'd3);
                ixv = ix[4:0];
                gv  = g[1:0];
                exp_q.push_back({ixv, gv, 1'(src < OFFSET), 1'(p == 3), 1'(k == 2 && p == 3)});
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_in_ready", in_ready, 1);
                exp_q.delete();
                timer = 0;
                interval_armed = 0;
            end else begin
                int pending, occ;
                bit exp_ov, exp_ir;
                logic [W-1:0] word;
                pending = (timer > TOTAL) ? TOTAL : timer;
                occ     = exp_q.size() - pending;
                exp_ov  = (occ > 0);
                exp_ir  = (timer == 0) && (DEPTH - occ >= TOTAL);
                word    = {out_index, out_gfm, out_clip, out_last_part, out_last};
                check("busy", busy, 32'(timer > 0));
                check("out_valid", out_valid, 32'(exp_ov));
                check("in_ready", in_ready, 32'(exp_ir));
                if (!exp_ov) begin
                    check("idle_payload", word, 0);
                end else if (out_ready) begin
                    check("beat", word, exp_q.pop_front());
                end
                if (timer > 0) timer--;
                if (in_valid && exp_ir) begin
                    model_job(in_fragment, in_kmer_indices);
                    timer = JOB_CYCLES;
                    if (chk_interval && interval_armed) check("accept_interval", cyc - last_acc, 14);
                    interval_armed = chk_interval;
                    last_acc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_job(input logic [7:0] frag, input logic [14:0] idxs, input bit hold);
        int n;
        bit ok;
        in_fragment     = frag;
        in_kmer_indices = idxs;
        in_valid        = 1'b1;
        n  = 0;
        ok = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    function automatic logic [4:0] rand_idx();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        int n;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Reference job: fragment E4, indices 3/5/7.
        out_ready = 1'b1;
        send_job(8'hE4, {5'd7, 5'd5, 5'd3}, 0);
        idle(16);

        // Clip boundary around OFFSET.
        send_job(8'($urandom), {rand_idx(), rand_idx(), 5'd1}, 0);
        send_job(8'($urandom), {rand_idx(), rand_idx(), 5'd2}, 0);
        send_job(8'($urandom), {5'd0, 5'd1, 5'd31}, 0);
        idle(16);

        // Backpressure: second job waits for 8 pops, then push+pop at depth 15.
        out_ready = 1'b0;
        send_job(8'hA5, {5'd9, 5'd0, 5'd17}, 1);
        fork
            send_job(8'h3C, {5'd2, 5'd30, 5'd1}, 0);
            begin
                idle(20);
                out_ready = 1'b1;
                idle(8);
                out_ready = 1'b0;
            end
        join
        idle(12);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(20);

        // Continuous jobs: one accept every 14 cycles.
        chk_interval = 1'b1;
        for (int j = 0; j < 4; j++) begin
            send_job(8'($urandom), {rand_idx(), rand_idx(), rand_idx()}, 1);
        end
        in_valid = 1'b0;
        chk_interval = 1'b0;
        idle(16);

        // Reset while RUN is at beat 5.
        send_job(8'h5A, {5'd4, 5'd6, 5'd8}, 0);
        idle(6);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_job(8'h1B, {5'd12, 5'd20, 5'd9}, 0);
        idle(16);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                if ($urandom_range(0, 2) != 0) begin
                    in_valid        = 1'b1;
                    in_fragment     = 8'($urandom);
                    in_kmer_indices = {rand_idx(), rand_idx(), rand_idx()};
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        n = 0;
        while ((exp_q.size() != 0 || timer != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
